// File: rtl/mpmc_line_port.sv
// Cache-line initiator for a 32-bit cmd/rd/wr FIFO memory-controller port.
// One line request becomes one burst: read = cmd then drain rd FIFO; write = fill wr FIFO, cmd, wait empty.
module mpmc_line_port #(
  parameter int WORDS = 8,
  parameter int TMO   = 1023
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [29:0] adr_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [5:0]  idx_o,
  output logic [31:0] rdat_o,
  output logic        rvld_o,
  input  logic [31:0] wdat_i,
  output logic        cmd_en,
  output logic [2:0]  cmd_instr,
  output logic [5:0]  cmd_bl,
  output logic [29:0] cmd_byte_addr,
  input  logic        cmd_full,
  output logic        rd_en,
  input  logic [31:0] rd_data,
  input  logic        rd_empty,
  output logic        wr_en,
  output logic [31:0] wr_data,
  input  logic        wr_full,
  input  logic        wr_empty
);

  localparam int              TW    = $clog2(TMO + 1);
  localparam logic [5:0]      LAST  = 6'(WORDS - 1);
  localparam logic [29:0]     AMASK = ~30'(WORDS * 4 - 1);
  localparam logic [TW-1:0]   TLIM  = TW'(TMO - 1);

  typedef enum logic [2:0] {IDLE, WFILL, CMD, RDATA, WDRAIN, DONE} state_e;

  // rd (not we) is stored so the reset value of cmd_instr comes out as 000
  typedef struct packed {
    logic        rd;
    logic [29:0] adr;
  } line_req_t;

  state_e        state_q;
  line_req_t     req_q;
  logic          busy_q, done_q, err_q, rvld_q;
  logic [5:0]    idx_q, cnt_q;
  logic [31:0]   rdat_q;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          progress, tmo_hit;

  assign wr_en    = (state_q == WFILL) && !wr_full;
  assign cmd_en   = (state_q == CMD)   && !cmd_full;
  assign rd_en    = (state_q == RDATA) && !rd_empty;
  assign wr_data  = wdat_i;

  // Any handshake restarts the stall timer; expiry only matters when nothing moved
  assign progress = wr_en | cmd_en | rd_en;
  assign tmr_d    = progress ? '0 : tmr_q + TW'(1);
  assign tmo_hit  = !progress && (tmr_q == TLIM);

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign idx_o         = idx_q;
  assign rdat_o        = rdat_q;
  assign rvld_o        = rvld_q;
  assign cmd_instr     = {2'b00, req_q.rd};
  assign cmd_bl        = LAST;
  assign cmd_byte_addr = req_q.adr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      req_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rvld_q  <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      rdat_q  <= '0;
      tmr_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      rvld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            req_q   <= '{rd: !we_i, adr: adr_i & AMASK};
            busy_q  <= 1'b1;
            idx_q   <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            state_q <= we_i ? WFILL : CMD;
          end
        end
        WFILL: begin
          tmr_q <= tmr_d;
          if (wr_en) begin
            if (idx_q == LAST) state_q <= CMD;
            else               idx_q   <= idx_q + 6'd1;
          end else if (tmo_hit) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end
        end
        CMD: begin
          tmr_q <= tmr_d;
          if (cmd_en) begin
            if (req_q.rd) begin
              state_q <= RDATA;
              idx_q   <= '0;
              cnt_q   <= '0;
            end else begin
              state_q <= WDRAIN;
            end
          end else if (tmo_hit) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end
        end
        RDATA: begin
          tmr_q <= tmr_d;
          if (rd_en) begin
            // cnt_q tracks pops; idx_q is presented alongside the registered word
            rdat_q <= rd_data;
            rvld_q <= 1'b1;
            idx_q  <= cnt_q;
            cnt_q  <= cnt_q + 6'd1;
            if (cnt_q == LAST) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end else if (tmo_hit) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end
        end
        WDRAIN: begin
          tmr_q <= tmr_d;
          if (wr_empty) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (tmo_hit) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          tmr_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpmc_line_port.sv
// Randomized bench for mpmc_line_port: behavioural FIFO models plus per-line expectations.
module tb_mpmc_line_port;
  localparam int WORDS = 8;
  localparam int TMO   = 15;
  localparam int IB    = $clog2(WORDS);

  logic        clk_i = 1'b0, rst_ni = 1'b1;
  logic        req_i, we_i;
  logic [29:0] adr_i;
  logic        busy_o, done_o, err_o, rvld_o;
  logic [5:0]  idx_o;
  logic [31:0] rdat_o, wdat_i;
  logic        cmd_en, cmd_full;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic        rd_en, rd_empty;
  logic [31:0] rd_data;
  logic        wr_en, wr_full, wr_empty;
  logic [31:0] wr_data;

  mpmc_line_port #(.WORDS(WORDS), .TMO(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .adr_i(adr_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .idx_o(idx_o),
    .rdat_o(rdat_o), .rvld_o(rvld_o), .wdat_i(wdat_i),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
    .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
    .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full), .wr_empty(wr_empty)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0, n_fail = 0, cyc_n = 0;
  logic [31:0] line  [WORDS];
  logic [31:0] wline [WORDS];
  logic [31:0] rq[$];
  logic [5:0]  rv_idx[$];
  logic [31:0] rv_dat[$];
  logic [31:0] wpush[$];
  int n_cmd, n_done, n_pop, rd_viol, wr_viol, cmd_viol, wq_cnt, wq_at_done, push_at_cmd;
  int cmd_cyc, req_cyc, done_cyc, last_pop_cyc, rd_hold, cmd_hold;
  logic [2:0]  cmd_instr_s;
  logic [29:0] cmd_addr_s;
  logic [5:0]  cmd_bl_s;
  logic        err_s;
  bit draining, init_stall, mid_stall, wfull_tog;

  // line buffer read port, indexed combinationally by the DUT
  assign wdat_i = wline[idx_o[IB-1:0]];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint line_base(input logic [29:0] a);
    longint la = longint'(a);
    return la - (la % (WORDS * 4));
  endfunction

  // One clock: observe at negedge, then drive FIFO-model inputs just after posedge
  task automatic cyc();
    @(negedge clk_i);
    if (rd_en) begin
      if (rd_empty) rd_viol++;
      else if (rq.size() > 0) begin
        void'(rq.pop_front());
        n_pop++;
        last_pop_cyc = cyc_n;
      end
    end
    if (wr_en) begin
      if (wr_full) wr_viol++;
      wpush.push_back(wr_data);
      wq_cnt++;
    end
    if (cmd_en) begin
      if (cmd_full) cmd_viol++;
      n_cmd++;
      cmd_cyc = cyc_n;
      cmd_instr_s = cmd_instr;
      cmd_addr_s = cmd_byte_addr;
      cmd_bl_s = cmd_bl;
      push_at_cmd = wpush.size();
      draining = 1'b1;
      if (init_stall) rd_hold = 3;
    end
    if (rvld_o) begin
      rv_idx.push_back(idx_o);
      rv_dat.push_back(rdat_o);
    end
    if (done_o) begin
      n_done++;
      done_cyc = cyc_n;
      err_s = err_o;
      wq_at_done = wq_cnt;
    end
    @(posedge clk_i);
    cyc_n++;
    #1;
    if (cmd_hold > 0) begin cmd_full = 1'b1; cmd_hold--; end
    else cmd_full = 1'b0;
    if (mid_stall && n_pop == 4) begin rd_hold = 2; mid_stall = 1'b0; end
    if (rd_hold > 0) begin rd_empty = 1'b1; rd_hold--; end
    else rd_empty = (rq.size() == 0);
    rd_data = (rq.size() > 0) ? rq[0] : $urandom;
    wr_full = wfull_tog ? cyc_n[0] : 1'b0;
    if (draining && wq_cnt > 0) wq_cnt--;
    wr_empty = (wq_cnt == 0);
  endtask

  task automatic clear_bk();
    rv_idx.delete(); rv_dat.delete(); wpush.delete();
    n_cmd = 0; n_done = 0; n_pop = 0; rd_viol = 0; wr_viol = 0; cmd_viol = 0;
    wq_cnt = 0; wq_at_done = -1; push_at_cmd = -1; draining = 1'b0; err_s = 1'b0;
    cmd_cyc = -1; done_cyc = -1; last_pop_cyc = -1; rd_hold = 0; cmd_hold = 0;
  endtask

  task automatic fill_line(input int nrd);
    rq.delete();
    for (int k = 0; k < WORDS; k++) begin
      line[k]  = $urandom;
      wline[k] = {6'(k), 26'($urandom)};
    end
    for (int k = 0; k < nrd; k++) rq.push_back(line[k]);
  endtask

  task automatic run_txn(input bit we, input logic [29:0] adr, input int cstall, input bit busyreq);
    clear_bk();
    we_i = we; adr_i = adr; req_i = 1'b1; req_cyc = cyc_n; cmd_hold = cstall;
    cyc();
    req_i = 1'b0; we_i = 1'($urandom); adr_i = 30'($urandom);
    chk("busy_accept", longint'(busy_o), 1);
    for (int k = 0; k < 400 && n_done == 0; k++) begin
      if (busyreq) req_i = (rv_idx.size() >= 2 && rv_idx.size() <= 4);
      cyc();
    end
    req_i = 1'b0;
    if (n_done == 0) chk("txn_budget", 0, 1);
    repeat (3) cyc();
    chk("busy_idle", longint'(busy_o), 0);
  endtask

  task automatic check_read(input string t, input logic [29:0] adr, input int nexp, input bit exp_err);
    chk({t, "_ncmd"}, longint'(n_cmd), 1);
    chk({t, "_instr"}, longint'(cmd_instr_s), 1);
    chk({t, "_addr"}, longint'(cmd_addr_s), line_base(adr));
    chk({t, "_bl"}, longint'(cmd_bl_s), WORDS - 1);
    chk({t, "_nwords"}, longint'(rv_idx.size()), longint'(nexp));
    for (int k = 0; k < rv_idx.size() && k < WORDS; k++) begin
      chk({t, "_idx"}, longint'(rv_idx[k]), longint'(k));
      chk({t, "_dat"}, longint'(rv_dat[k]), longint'(line[k]));
    end
    chk({t, "_ndone"}, longint'(n_done), 1);
    chk({t, "_err"}, longint'(err_s), longint'(exp_err));
    chk({t, "_rd_when_empty"}, longint'(rd_viol), 0);
    chk({t, "_cmd_when_full"}, longint'(cmd_viol), 0);
  endtask

  task automatic check_write(input string t, input logic [29:0] adr);
    chk({t, "_ncmd"}, longint'(n_cmd), 1);
    chk({t, "_instr"}, longint'(cmd_instr_s), 0);
    chk({t, "_addr"}, longint'(cmd_addr_s), line_base(adr));
    chk({t, "_bl"}, longint'(cmd_bl_s), WORDS - 1);
    chk({t, "_push_before_cmd"}, longint'(push_at_cmd), WORDS);
    chk({t, "_npush"}, longint'(wpush.size()), WORDS);
    for (int k = 0; k < wpush.size() && k < WORDS; k++)
      chk({t, "_wdat"}, longint'(wpush[k]), longint'(wline[k]));
    chk({t, "_wr_when_full"}, longint'(wr_viol), 0);
    chk({t, "_drained_at_done"}, longint'(wq_at_done), 0);
    chk({t, "_ndone"}, longint'(n_done), 1);
    chk({t, "_err"}, longint'(err_s), 0);
    chk({t, "_no_rvld"}, longint'(rv_idx.size()), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [29:0] radr;
    bit rwe;
    int n0;
    req_i = 0; we_i = 0; adr_i = 0; cmd_full = 0; rd_data = 0; rd_empty = 0;
    wr_full = 0; wr_empty = 1;
    init_stall = 0; mid_stall = 0; wfull_tog = 0;
    clear_bk();
    fill_line(0);
    #1 rst_ni = 1'b0;
    #2;
    chk("rst_busy", longint'(busy_o), 0);
    chk("rst_done_err", longint'({done_o, err_o, rvld_o}), 0);
    chk("rst_idx", longint'(idx_o), 0);
    chk("rst_rdat", longint'(rdat_o), 0);
    chk("rst_strobes", longint'({cmd_en, rd_en, wr_en}), 0);
    chk("rst_instr", longint'(cmd_instr), 0);
    chk("rst_bl", longint'(cmd_bl), WORDS - 1);
    chk("rst_addr", longint'(cmd_byte_addr), 0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (2) cyc();

    // plain line fill from the top of the address space
    fill_line(WORDS);
    run_txn(1'b0, 30'h3FFF_F01C, 0, 1'b0);
    check_read("fill", 30'h3FFF_F01C, WORDS, 1'b0);
    chk("fill_addr_abs", longint'(cmd_addr_s), longint'(30'h3FFF_F000));

    // read FIFO empty 3 cycles up front and 2 cycles mid-burst
    fill_line(WORDS);
    radr = 30'($urandom);
    init_stall = 1; mid_stall = 1;
    run_txn(1'b0, radr, 0, 1'b0);
    init_stall = 0; mid_stall = 0;
    check_read("stall", radr, WORDS, 1'b0);

    // writeback with wr_full toggling
    fill_line(0);
    radr = 30'($urandom);
    wfull_tog = 1;
    run_txn(1'b1, radr, 0, 1'b0);
    wfull_tog = 0;
    check_write("wb", radr);

    // cmd_full held for 5 cycles after accept
    fill_line(WORDS);
    radr = 30'($urandom);
    run_txn(1'b0, radr, 5, 1'b0);
    check_read("cfull", radr, WORDS, 1'b0);
    chk("cfull_lat", longint'(cmd_cyc - req_cyc), 6);

    // timeout: only 3 words ever arrive
    fill_line(3);
    radr = 30'($urandom);
    run_txn(1'b0, radr, 0, 1'b0);
    check_read("tmo", radr, 3, 1'b1);
    chk("tmo_lat", longint'(done_cyc - last_pop_cyc), TMO + 1);
    n0 = n_pop;
    for (int k = 3; k < WORDS; k++) rq.push_back(line[k]);
    repeat (6) cyc();
    chk("tmo_no_pop_after", longint'(n_pop), longint'(n0));
    rq.delete();

    // req_i pulsed while busy must not start a second burst
    fill_line(WORDS);
    radr = 30'($urandom);
    run_txn(1'b0, radr, 0, 1'b1);
    check_read("busyreq", radr, WORDS, 1'b0);

    // asynchronous reset in the middle of a read burst
    fill_line(WORDS);
    clear_bk();
    we_i = 1'b0; adr_i = 30'($urandom); req_i = 1'b1;
    cyc();
    req_i = 1'b0;
    for (int k = 0; k < 100 && rv_idx.size() < 2; k++) cyc();
    #2 rst_ni = 1'b0;
    #1;
    chk("mrst_busy", longint'(busy_o), 0);
    chk("mrst_idx", longint'(idx_o), 0);
    chk("mrst_rvld", longint'(rvld_o), 0);
    chk("mrst_strobes", longint'({cmd_en, rd_en, wr_en}), 0);
    cyc();
    rst_ni = 1'b1;
    n0 = n_cmd;
    repeat (8) cyc();
    chk("mrst_no_cmd", longint'(n_cmd), longint'(n0));
    chk("mrst_no_done", longint'(n_done), 0);
    chk("mrst_idle", longint'(busy_o), 0);
    rq.delete();

    // random mix of reads and writes with random stalls
    for (int t = 0; t < 8; t++) begin
      rwe = 1'($urandom);
      radr = 30'($urandom);
      fill_line(rwe ? 0 : WORDS);
      init_stall = 1'($urandom); mid_stall = 1'($urandom); wfull_tog = 1'($urandom);
      run_txn(rwe, radr, $urandom_range(0, 4), 1'b0);
      init_stall = 0; mid_stall = 0; wfull_tog = 0;
      if (rwe) check_write("rnd_wb", radr);
      else     check_read("rnd_rd", radr, WORDS, 1'b0);
      rq.delete();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mpmc_line_port.md
Name: mpmc_line_port

Overview:
- Initiator side of the 32-bit memory-controller command/FIFO port (cmd/rd/wr FIFOs) used by Raptor64mc for cache-line traffic.
- Converts one line request from the cache controller into a single burst command:
  - read: cmd then drain the read FIFO
  - write: fill the write FIFO, then cmd, then wait for drain
- Returns read words to the line buffer with an index, and signals done/error.

Parameters:
- WORDS, 8, 32-bit words per line (power of 2, 2..64); cmd_bl = WORDS-1.
- TMO, 1023, idle cycles allowed while waiting on any port handshake before error abort.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  line request strobe, sampled only in IDLE
- we_i  in  1  1 = line write (writeback), 0 = line read (fill)
- adr_i  in  30  byte address; low log2(WORDS*4) bits ignored (forced 0)
- busy_o  out  1  high from request accept until done
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  with done_o: transfer aborted by timeout
- idx_o  out  6  word index of current line word (rd capture or wr fetch)
- rdat_o  out  32  read word to line buffer
- rvld_o  out  1  rdat_o/idx_o valid this cycle
- wdat_i  in  32  write word for index idx_o (combinational from line buffer)
- cmd_en  out  1  command push
- cmd_instr  out  3  000 write, 001 read
- cmd_bl  out  6  WORDS-1
- cmd_byte_addr  out  30  aligned line address
- cmd_full  in  1  command FIFO full
- rd_en  out  1  read FIFO pop; first-word-fall-through, data valid same cycle
- rd_data  in  32  read FIFO data
- rd_empty  in  1  read FIFO empty
- wr_en  out  1  write FIFO push
- wr_data  out  32  = wdat_i
- wr_full  in  1  write FIFO full
- wr_empty  in  1  write FIFO empty

Behaviour:
- Reset values (async, rst_ni low): state IDLE; all outputs 0; cmd_instr 000; cmd_bl WORDS-1 (constant); word count, idx_o, timer 0.
- States: IDLE, WFILL, CMD, RDATA, WDRAIN, DONE.
- IDLE:
  - On req_i: latch we_i and the aligned address; busy_o <= 1; idx_o <= 0; timer <= 0.
  - Next state WFILL if we_i, else CMD.
- WFILL:
  - wr_en = !wr_full (combinational); wr_data = wdat_i.
  - On each push, idx_o increments; after push of index WORDS-1, go to CMD.
- CMD:
  - cmd_en = !cmd_full for exactly one accepted cycle.
  - cmd_instr = 000 if write, 001 if read; cmd_byte_addr = latched address.
  - After accept: write goes to WDRAIN; read goes to RDATA with idx_o = 0.
- RDATA:
  - rd_en = !rd_empty; on pop, rdat_o <= rd_data, rvld_o <= 1 next cycle with the matching idx_o (1-cycle registered latency), then the index increments.
  - After pop WORDS-1, go to DONE.
  - rd_en is never asserted while rd_empty = 1.
- WDRAIN: wait for wr_empty = 1, then go to DONE.
- DONE:
  - done_o = 1 for one cycle; busy_o <= 0; return to IDLE.
  - A new req_i is accepted no earlier than the cycle after done_o.
- Timeout:
  - The timer counts cycles in WFILL, CMD, RDATA and WDRAIN with no handshake progress; it clears on any push, pop or command accept.
  - When the timer reaches TMO: go to DONE with err_o = 1 (same cycle as done_o). No further cmd_en/rd_en/wr_en is issued.
  - Words already delivered on rvld_o stand.
- req_i while busy: ignored (no queueing).
- Index width: idx_o is 6 bits; only the low log2(WORDS) bits are significant; no wrap past WORDS-1.
- Reset mid-transfer: immediate return to IDLE, all strobes low. FIFO contents are the controller's responsibility.

Test Plan:
- Read fill, adr_i=30'h3FFF_F01C, WORDS=8 -> one cmd_en with cmd_instr=001, cmd_byte_addr=30'h3FFF_F000, cmd_bl=7; 8 rvld_o pulses idx 0..7 with FIFO data in order; done_o, err_o=0.
- Read with rd_empty high for 3 cycles before the first word and 2 cycles mid-burst -> rd_en never high while empty; data order and indices intact; single done_o.
- Line write, wdat_i = {idx, 26'h0} pattern, wr_full toggling every other cycle -> exactly 8 wr_en pushes of the correct data before cmd_en (instr 000); done_o only after wr_empty=1.
- cmd_full held high 5 cycles -> cmd_en stays low, then exactly one cmd_en cycle when cmd_full drops.
- TMO=15, rd_empty stuck high after 3 words -> done_o with err_o=1 16 cycles after last pop; busy_o falls; no further rd_en.
- rst_ni pulsed low in RDATA, and req_i asserted while busy -> outputs zero asynchronously, IDLE on release; the busy request produces no second cmd_en.
